// File: rtl/arb_mux_nto1_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrated multiplexer.
package arb_mux_nto1_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Width of a channel index: clog2(n), but never narrower than one bit.
  function automatic int calc_sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_mux_nto1_rr_arbiter.sv
// Grant generation and priority pointer for the N-to-1 multiplexer.
// Round-robin scans upward from the pointer; fixed mode keeps the pointer at 0.
module rr_arbiter
  import arb_mux_nto1_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int MODE   = MODE_RR,
  localparam int SEL_W = calc_sel_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] valid,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] next_ptr;
  logic             found;
  int               scan_idx;

  // Scan from the pointer upward with wrap and grant the first valid channel.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_IN) begin
        scan_idx = scan_idx - NUM_IN;
      end
      if (!found && valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = SEL_W'(scan_idx);
      end
    end
  end

  // Pointer successor of the granted channel, wrapping explicitly so that a
  // non-power-of-two channel count never reaches an out-of-range index.
  always_comb begin
    next_ptr = '0;
    if (int'(grant_idx) != NUM_IN - 1) begin
      next_ptr = grant_idx + SEL_W'(1);
    end
  end

  // Pointer moves only when the granted channel actually transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (MODE == MODE_RR && advance) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/arb_mux_nto1.sv
// N-to-1 arbitrated multiplexer with a single-entry registered output stage.
module arb_mux_nto1
  import arb_mux_nto1_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int MODE   = MODE_RR,
  localparam int SEL_W = calc_sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load_en;
  logic              in_xfer;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .MODE   (MODE)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .valid     (in_valid),
    .advance   (in_xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready goes only to the granted channel, only when the output slot can take
  // a beat, and never while reset is asserted.
  always_comb begin
    load_en  = ~out_valid | out_ready;
    in_ready = reset ? '0 : (grant & {NUM_IN{load_en}});
    in_xfer  = |in_ready;
  end

  // One-hot data select driven by the grant vector.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot: load on an input transfer, empty on a bare output transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_nto1.sv
// Self-checking bench: three instances (4-ch round-robin, 4-ch fixed priority,
// 3-ch round-robin) checked every cycle against a behavioural model.
module tb_arb_mux_nto1;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   v0, v1, ir0, ir1;
  logic [2:0]   v2, ir2;
  logic [127:0] d0, d1;
  logic [95:0]  d2;
  logic         r0, r1, r2, ov0, ov1, ov2;
  logic [31:0]  od0, od1, od2;
  logic [1:0]   os0, os1, os2;

  int checks = 0;
  int errors = 0;
  bit live   = 1'b0;

  int          m_ptr [3];
  bit          m_ov  [3];
  logic [31:0] m_od  [3];
  int          m_os  [3];
  logic [33:0] sbq[$];

  always #5 clk = ~clk;

  arb_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut_rr (
    .clk(clk), .reset(rst), .in_data(d0), .in_valid(v0), .in_ready(ir0),
    .out_data(od0), .out_valid(ov0), .out_ready(r0), .out_sel(os0));

  arb_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut_fx (
    .clk(clk), .reset(rst), .in_data(d1), .in_valid(v1), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(r1), .out_sel(os1));

  arb_mux_nto1 #(.WIDTH(32), .NUM_IN(3), .MODE(0)) dut_n3 (
    .clk(clk), .reset(rst), .in_data(d2), .in_valid(v2), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(r2), .out_sel(os2));

  function automatic logic [3:0] vin(input int d);
    case (d)
      0:       return v0;
      1:       return v1;
      default: return {1'b0, v2};
    endcase
  endfunction

  function automatic logic [31:0] din(input int d, input int c);
    case (d)
      0:       return d0[c*32 +: 32];
      1:       return d1[c*32 +: 32];
      default: return d2[c*32 +: 32];
    endcase
  endfunction

  function automatic bit ordy(input int d);
    case (d)
      0:       return r0;
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic [3:0] act_ir(input int d);
    case (d)
      0:       return ir0;
      1:       return ir1;
      default: return {1'b0, ir2};
    endcase
  endfunction

  function automatic logic [33:0] act_out(input int d);
    case (d)
      0:       return {os0, od0};
      1:       return {os1, od1};
      default: return {os2, od2};
    endcase
  endfunction

  function automatic bit act_ov(input int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  // Winner under the arbitration rules, or -1 when nothing is valid.
  function automatic int exp_grant(input int d);
    int n;
    int start;
    logic [3:0] v;
    n     = (d == 2) ? 3 : 4;
    v     = vin(d);
    start = (d == 1) ? 0 : m_ptr[d];
    for (int k = 0; k < n; k++) begin
      if (v[(start + k) % n]) return (start + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ir(input int d);
    int g;
    if (rst || (m_ov[d] && !ordy(d))) return 4'b0000;
    g = exp_grant(d);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d actual=%h required=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Model update at each rising edge; scoreboard pops the beat leaving dut_rr.
  always @(posedge clk) begin
    int g;
    int n;
    logic [33:0] e;
    if (live && !rst && ov0 && r0) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_underflow", 0, 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("sb_data", 0, od0, e[31:0]);
        checkOutput("sb_sel", 0, 32'(os0), 32'(e[33:32]));
      end
    end
    if (rst) sbq.delete();
    for (int d = 0; d < 3; d++) begin
      n = (d == 2) ? 3 : 4;
      if (rst) begin
        m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = 0; m_ptr[d] = 0;
      end else begin
        g = exp_grant(d);
        if ((!m_ov[d] || ordy(d)) && g >= 0) begin
          m_ov[d] = 1'b1;
          m_od[d] = din(d, g);
          m_os[d] = g;
          if (d != 1) m_ptr[d] = (g + 1) % n;
          if (d == 0) sbq.push_back({2'(g), din(0, g)});
        end else if (m_ov[d] && ordy(d)) begin
          m_ov[d] = 1'b0;
        end
      end
    end
    if (rst) live = 1'b1;
  end

  // Compare every output of every instance against the model mid-cycle.
  always @(negedge clk) begin
    logic [33:0] a;
    if (live) begin
      for (int d = 0; d < 3; d++) begin
        a = act_out(d);
        checkOutput("in_ready", d, 32'(act_ir(d)), 32'(exp_ir(d)));
        checkOutput("in_ready_onehot0", d, 32'($onehot0(act_ir(d))), 32'd1);
        checkOutput("out_valid", d, 32'(act_ov(d)), 32'(m_ov[d]));
        checkOutput("out_data", d, a[31:0], m_od[d]);
        checkOutput("out_sel", d, 32'(a[33:32]), 32'(m_os[d]));
      end
    end
  end

  initial begin
    int seq [8];
    seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst = 1'b1;
    v0 = '0; v1 = '0; v2 = '0; r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
    d0 = {32'hC3C3_0003, 32'hDEAD_BEEF, 32'hC1C1_0001, 32'hC0C0_0000};
    d1 = {32'h1333_0003, 32'h1222_0002, 32'h1111_0001, 32'h1000_0000};
    d2 = {32'h2222_0002, 32'h2111_0001, 32'h2000_0000};
    repeat (2) applyStimulus();
    checkOutput("reset_out_valid", 0, 32'(ov0), 32'd0);
    checkOutput("reset_out_data", 0, od0, 32'd0);
    rst = 1'b0;

    // Round-robin rotation on dut_rr alongside fixed priority on dut_fx.
    v0 = 4'b1111; r0 = 1'b1;
    v1 = 4'b1010; r1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput("rr_valid", 0, 32'(ov0), 32'd1);
      checkOutput("rr_seq", 0, 32'(os0), 32'(seq[i]));
      checkOutput("fx_sel", 1, 32'(os1), 32'd1);
      checkOutput("fx_ch3_ready", 1, 32'(ir1[3]), 32'd0);
    end

    // Backpressure holding the channel-2 beat, then release.
    v0 = 4'b0100;
    applyStimulus();
    checkOutput("bp_load_sel", 0, 32'(os0), 32'd2);
    v0 = 4'b1111; r0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("bp_data", 0, od0, 32'hDEAD_BEEF);
      checkOutput("bp_sel", 0, 32'(os0), 32'd2);
      checkOutput("bp_ready", 0, 32'(ir0), 32'd0);
    end
    r0 = 1'b1;
    applyStimulus();
    checkOutput("bp_next_sel", 0, 32'(os0), 32'd3);
    checkOutput("bp_next_data", 0, od0, 32'hC3C3_0003);

    // Wrap on the 3-channel instance with the pointer parked at 2.
    v2 = 3'b010; r2 = 1'b1;
    applyStimulus();
    checkOutput("n3_first", 2, 32'(os2), 32'd1);
    v2 = 3'b011;
    applyStimulus();
    checkOutput("n3_wrap", 2, 32'(os2), 32'd0);
    applyStimulus();
    checkOutput("n3_ptr1", 2, 32'(os2), 32'd1);
    v2 = 3'b000;

    // Reset pulse while a beat is held.
    v0 = 4'b0010; r0 = 1'b0;
    applyStimulus();
    checkOutput("rst_held_valid", 0, 32'(ov0), 32'd1);
    rst = 1'b1; v0 = 4'b1111; r0 = 1'b1;
    #1;
    checkOutput("rst_in_ready", 0, 32'(ir0), 32'd0);
    applyStimulus();
    checkOutput("rst_out_valid", 0, 32'(ov0), 32'd0);
    checkOutput("rst_out_data", 0, od0, 32'd0);
    checkOutput("rst_out_sel", 0, 32'(os0), 32'd0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("rst_first_grant", 0, 32'(os0), 32'd0);
    checkOutput("rst_first_valid", 0, 32'(ov0), 32'd1);

    // Random stress with occasional resets.
    for (int i = 0; i < 10000; i++) begin
      v0 = 4'($urandom); v1 = 4'($urandom); v2 = 3'($urandom);
      d0 = {$urandom, $urandom, $urandom, $urandom};
      d1 = {$urandom, $urandom, $urandom, $urandom};
      d2 = {$urandom, $urandom, $urandom};
      r0 = ($urandom_range(0, 9) < 7); r1 = ($urandom_range(0, 9) < 7);
      r2 = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end

    // Drain and confirm nothing is left outstanding.
    rst = 1'b0; v0 = '0; v1 = '0; v2 = '0; r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("sb_empty", 0, 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
